dvsd_binary_counter_4bit: RTL and testbench



---
 rtl/dvsd_binary_counter_4bit_pkg.sv | 15 +
 rtl/dvsd_binary_counter_4bit_updown_step.sv | 23 ++
 rtl/dvsd_binary_counter_4bit.sv | 37 +++
 tb/tb_dvsd_binary_counter_4bit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dvsd_binary_counter_4bit_pkg.sv
// Shared constants and types for the 4-bit up/down binary counter.
package dvsd_binary_counter_4bit_pkg;

  // Counter width and the value the register takes under reset.
  localparam int unsigned CNT_WIDTH     = 4;
  localparam int unsigned CNT_RESET_VAL = 0;

  // Direction select encodings for the updown input.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Count value type.
  typedef logic [CNT_WIDTH-1:0] cnt_t;

endpackage : dvsd_binary_counter_4bit_pkg

// File: rtl/dvsd_binary_counter_4bit_updown_step.sv
// Combinational +1 / -1 step of a WIDTH-bit count. Arithmetic wraps
// naturally modulo 2^WIDTH because the result is truncated to WIDTH bits.
module updown_step
  import dvsd_binary_counter_4bit_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             updown,
  output logic [WIDTH-1:0] next_cnt
);

  // Select increment or decrement of the current count from the direction bit.
  always_comb begin
    next_cnt = cnt;
    case (updown)
      DIR_UP:   next_cnt = cnt + WIDTH'(1);
      DIR_DOWN: next_cnt = cnt - WIDTH'(1);
      default:  next_cnt = cnt;
    endcase
  end

endmodule : updown_step

// File: rtl/dvsd_binary_counter_4bit.sv
// Free-running 4-bit binary up/down counter with asynchronous active-high
// reset. The output is taken straight from the count register, so there is
// no combinational path from any input to out.
module dvsd_binary_counter_4bit
  import dvsd_binary_counter_4bit_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             updown,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] next_cnt_s;

  updown_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .cnt      (cnt_r),
    .updown   (updown),
    .next_cnt (next_cnt_s)
  );

  // Count register: cleared immediately by reset, otherwise steps every edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= WIDTH'(CNT_RESET_VAL);
    end else begin
      cnt_r <= next_cnt_s;
    end
  end

  assign out = cnt_r;

endmodule : dvsd_binary_counter_4bit

// File: tb/tb_dvsd_binary_counter_4bit.sv
// Directed self-checking bench for dvsd_binary_counter_4bit.
module tb_dvsd_binary_counter_4bit;

  logic       clk;
  logic       reset;
  logic       updown;
  logic [3:0] out;

  int vectors;
  int miscompares;

  dvsd_binary_counter_4bit #(
    .WIDTH (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .updown (updown),
    .out    (out)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety bound on total run time.
  initial begin
    #20000;
    $display("FAIL watchdog: run exceeded 20000 ns, required completion earlier");
    $fatal(1);
  end

  // Wait for the next rising edge and settle past clock-to-Q.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset across one clock, then release at a falling edge with a direction.
  task automatic restart(input logic dir);
    @(negedge clk);
    reset  = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    updown = dir;
  endtask

  task automatic test_reset();
    // Reset value while reset held from time 0.
    #1;
    vectors++;
    if (out !== 4'd0) begin
      $display("FAIL reset_init: out=%0d required 0", out);
      miscompares++;
    end
    restart(1'b1);
    for (int i = 0; i < 9; i++) tick();
    vectors++;
    if (out !== 4'd9) begin
      $display("FAIL reset_pre_count: out=%0d required 9", out);
      miscompares++;
    end
    // Raise reset mid-cycle, well away from any clock edge.
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (out !== 4'd0) begin
      $display("FAIL reset_async: out=%0d required 0", out);
      miscompares++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      updown = ~updown;
      tick();
      vectors++;
      if (out !== 4'd0) begin
        $display("FAIL reset_hold edge %0d: out=%0d required 0", i, out);
        miscompares++;
      end
    end
  endtask

  task automatic test_count_up();
    logic [3:0] exp_tbl [17];
    exp_tbl = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1};
    restart(1'b1);
    for (int i = 0; i < 17; i++) begin
      tick();
      vectors++;
      if (out !== exp_tbl[i]) begin
        $display("FAIL count_up edge %0d: out=%0d required %0d", i, out, exp_tbl[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_count_down();
    logic [3:0] exp_tbl [17];
    exp_tbl = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8, 4'd7,
                4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd15};
    restart(1'b0);
    for (int i = 0; i < 17; i++) begin
      tick();
      vectors++;
      if (out !== exp_tbl[i]) begin
        $display("FAIL count_down edge %0d: out=%0d required %0d", i, out, exp_tbl[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_direction_switch();
    logic [3:0] exp_tbl [8];
    exp_tbl = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd12, 4'd13, 4'd14};
    restart(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        @(negedge clk);
        updown = 1'b1;
      end
      tick();
      vectors++;
      if (out !== exp_tbl[i]) begin
        $display("FAIL dir_switch edge %0d: out=%0d required %0d", i, out, exp_tbl[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_long_run();
    restart(1'b1);
    for (int i = 0; i < 15; i++) tick();
    vectors++;
    if (out !== 4'd15) begin
      $display("FAIL long_run_top: out=%0d required 15", out);
      miscompares++;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (out !== 4'd0) begin
      $display("FAIL long_run_reset: out=%0d required 0", out);
      miscompares++;
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    vectors++;
    if (out !== 4'd1) begin
      $display("FAIL long_run_release: out=%0d required 1", out);
      miscompares++;
    end
  endtask

  task automatic test_reset_at_edge();
    restart(1'b1);
    for (int i = 0; i < 6; i++) tick();
    vectors++;
    if (out !== 4'd6) begin
      $display("FAIL edge_reset_pre: out=%0d required 6", out);
      miscompares++;
    end
    // Alternate direction so a missed reset would show as 5 or 7.
    updown = 1'b0;
    @(posedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (out !== 4'd0) begin
      $display("FAIL edge_reset: out=%0d required 0", out);
      miscompares++;
    end
    tick();
    vectors++;
    if (out !== 4'd0) begin
      $display("FAIL edge_reset_hold: out=%0d required 0", out);
      miscompares++;
    end
    @(negedge clk);
    reset  = 1'b0;
    updown = 1'b1;
    tick();
    vectors++;
    if (out !== 4'd1) begin
      $display("FAIL edge_reset_release: out=%0d required 1", out);
      miscompares++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    updown      = 1'b1;
    test_reset();
    test_count_up();
    test_count_down();
    test_direction_switch();
    test_long_run();
    test_reset_at_edge();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_dvsd_binary_counter_4bit
